// File: rtl/gcd_unit_queued.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gcd_unit_queued
// Purpose  : Queued, tagged subtractive-Euclid GCD engine with step counting.
// Revision : 1.0 - initial release
// ============================================================================

module gcd_unit_queued #(
   parameter int W     = 32,
   parameter int DEPTH = 4,
   parameter int TAGW  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [W-1:0]           operands_bits_A,
   input  logic [W-1:0]           operands_bits_B,
   input  logic [TAGW-1:0]        operands_bits_tag,
   input  logic                   operands_val,
   output logic                   operands_rdy,
   output logic [W-1:0]           result_bits_data,
   output logic [TAGW-1:0]        result_bits_tag,
   output logic [15:0]            result_bits_steps,
   output logic                   result_val,
   input  logic                   result_rdy,
   output logic [$clog2(DEPTH):0] queue_count
);

   localparam int          PW          = $clog2(DEPTH);
   localparam logic [PW:0] C_FULL      = (PW+1)'(DEPTH);
   localparam logic [PW:0] C_PTR_ONE   = (PW+1)'(1);
   localparam logic [15:0] C_STEPS_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   logic [W-1:0]    mem_a_q   [DEPTH];
   logic [W-1:0]    mem_b_q   [DEPTH];
   logic [TAGW-1:0] mem_tag_q [DEPTH];

   state_t          state_q, state_d;
   logic [PW:0]     wr_ptr_q, wr_ptr_d;
   logic [PW:0]     rd_ptr_q, rd_ptr_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [TAGW-1:0] tag_q, tag_d;
   logic [15:0]     steps_q, steps_d;
   logic            res_val_q, res_val_d;
   logic [W-1:0]    res_data_q, res_data_d;
   logic [TAGW-1:0] res_tag_q, res_tag_d;
   logic [15:0]     res_steps_q, res_steps_d;

   logic [PW:0]     w_count;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic [PW-1:0]   w_head;
   logic [15:0]     w_steps_inc;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_count     = wr_ptr_q - rd_ptr_q;
   assign w_full      = (w_count == C_FULL);
   assign w_empty     = (w_count == '0);
   assign w_push      = operands_val && !w_full;
   assign w_head      = rd_ptr_q[PW-1:0];
   assign w_steps_inc = (steps_q == C_STEPS_MAX) ? steps_q : steps_q + 16'd1;

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      tag_d       = tag_q;
      steps_d     = steps_q;
      res_val_d   = res_val_q;
      res_data_d  = res_data_q;
      res_tag_d   = res_tag_q;
      res_steps_d = res_steps_q;
      w_pop       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            w_pop = !w_empty;
         end
         ST_CALC: begin
            if (a_q < b_q) begin
               a_d     = b_q;
               b_d     = a_q;
               steps_d = w_steps_inc;
            end else if (b_q != '0) begin
               a_d     = a_q - b_q;
               steps_d = w_steps_inc;
            end else begin
               state_d     = ST_DONE;
               res_val_d   = 1'b1;
               res_data_d  = a_q;
               res_tag_d   = tag_q;
               res_steps_d = steps_q;
            end
         end
         ST_DONE: begin
            if (result_rdy) begin
               res_val_d = 1'b0;
               state_d   = ST_IDLE;
               w_pop     = !w_empty;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A pop from either IDLE or a completed handshake skips straight to CALC.
      if (w_pop) begin
         a_d     = mem_a_q[w_head];
         b_d     = mem_b_q[w_head];
         tag_d   = mem_tag_q[w_head];
         steps_d = '0;
         state_d = ST_CALC;
      end

      wr_ptr_d = w_push ? wr_ptr_q + C_PTR_ONE : wr_ptr_q;
      rd_ptr_d = w_pop  ? rd_ptr_q + C_PTR_ONE : rd_ptr_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         a_q         <= '0;
         b_q         <= '0;
         tag_q       <= '0;
         steps_q     <= '0;
         res_val_q   <= 1'b0;
         res_data_q  <= '0;
         res_tag_q   <= '0;
         res_steps_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         a_q         <= a_d;
         b_q         <= b_d;
         tag_q       <= tag_d;
         steps_q     <= steps_d;
         res_val_q   <= res_val_d;
         res_data_q  <= res_data_d;
         res_tag_q   <= res_tag_d;
         res_steps_q <= res_steps_d;
      end
   end

   // Storage needs no reset: the pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_a_q[wr_ptr_q[PW-1:0]]   <= operands_bits_A;
         mem_b_q[wr_ptr_q[PW-1:0]]   <= operands_bits_B;
         mem_tag_q[wr_ptr_q[PW-1:0]] <= operands_bits_tag;
      end
   end

   assign operands_rdy      = !w_full;
   assign queue_count       = w_count;
   assign result_val        = res_val_q;
   assign result_bits_data  = res_data_q;
   assign result_bits_tag   = res_tag_q;
   assign result_bits_steps = res_steps_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_unit_queued.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gcd_unit_queued
// Purpose  : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================

module tb_gcd_unit_queued;

   localparam int W = 32, DEPTH = 4, TAGW = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [W-1:0]    op_a, op_b;
   logic [TAGW-1:0] op_tag;
   logic            op_val, op_rdy;
   logic [W-1:0]    res_data;
   logic [TAGW-1:0] res_tag;
   logic [15:0]     res_steps;
   logic            res_val, res_rdy;
   logic [2:0]      q_count;

   gcd_unit_queued #(.W(W), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
      .clk               (clk),
      .reset             (reset),
      .operands_bits_A   (op_a),
      .operands_bits_B   (op_b),
      .operands_bits_tag (op_tag),
      .operands_val      (op_val),
      .operands_rdy      (op_rdy),
      .result_bits_data  (res_data),
      .result_bits_tag   (res_tag),
      .result_bits_steps (res_steps),
      .result_val        (res_val),
      .result_rdy        (res_rdy),
      .queue_count       (q_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  tag;
      int          steps;
   } res_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] data;
      int          steps;
      int          lat;
   } vec_t;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Euclid by division: q subtractions per remainder step, one swap after each.
   function automatic res_t model(input logic [31:0] a_in, input logic [31:0] b_in,
                                  input logic [3:0] tag);
      longint unsigned a = a_in, b = b_in, t, n = 0;
      res_t r;
      if (a < b) begin t = a; a = b; b = t; n++; end
      while (b != 0) begin
         n += a / b;
         a  = a % b;
         t = a; a = b; b = t;
         n++;
      end
      r.data  = a[31:0];
      r.tag   = tag;
      r.steps = (n > 65535) ? 65535 : int'(n);
      return r;
   endfunction

   vec_t        vecs [9];
   res_t        exp3 [3];
   res_t        expb [5];
   res_t        expq [$];
   res_t        e;
   int          cyc, k, prev, acc;
   bit          stable, held, saw;
   logic [51:0] snap;

   initial begin
      vecs[0] = '{32'd27,         32'd15,         4'd5,  32'd3,          9,     12};
      vecs[1] = '{32'd12,         32'd0,          4'd1,  32'd12,         0,     3};
      vecs[2] = '{32'd0,          32'd7,          4'd2,  32'd7,          1,     4};
      vecs[3] = '{32'd0,          32'd0,          4'd3,  32'd0,          0,     3};
      vecs[4] = '{32'd8,          32'd8,          4'd4,  32'd8,          2,     5};
      vecs[5] = '{32'd1,          32'd1,          4'd6,  32'd1,          2,     5};
      vecs[6] = '{32'd100,        32'd75,         4'd7,  32'd25,         6,     9};
      vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd8,  32'hFFFF_FFFF,  2,     5};
      vecs[8] = '{32'd65535,      32'd1,          4'd15, 32'd1,          65535, 65539};

      reset = 1'b1; op_a = '0; op_b = '0; op_tag = '0; op_val = 1'b0; res_rdy = 1'b0;
      step(); step();
      check("rst result_val", res_val, 0);
      check("rst data", res_data, 0);
      check("rst tag", res_tag, 0);
      check("rst steps", res_steps, 0);
      check("rst queue_count", q_count, 0);
      check("rst operands_rdy", op_rdy, 1);
      reset = 1'b0;
      step();

      // Single-operation latency and result vectors.
      foreach (vecs[i]) begin
         res_rdy = 1'b1;
         op_a = vecs[i].a; op_b = vecs[i].b; op_tag = vecs[i].tag; op_val = 1'b1;
         check($sformatf("vec%0d rdy", i), op_rdy, 1);
         step();
         op_val = 1'b0;
         cyc = 1;
         while (!res_val && cyc < 70000) begin step(); cyc++; end
         check($sformatf("vec%0d latency", i), cyc, vecs[i].lat);
         check($sformatf("vec%0d data", i), res_data, vecs[i].data);
         check($sformatf("vec%0d tag", i), res_tag, vecs[i].tag);
         check($sformatf("vec%0d steps", i), res_steps, vecs[i].steps);
         step();
         check($sformatf("vec%0d val drop", i), res_val, 0);
         step();
      end

      // Throughput: each result rises 2+N cycles after the previous handshake.
      res_rdy = 1'b1;
      exp3[0] = model(32'd9, 32'd3, 4'd1);
      exp3[1] = model(32'd8, 32'd8, 4'd2);
      exp3[2] = model(32'd5, 32'd0, 4'd3);
      op_val = 1'b1;
      op_a = 32'd9; op_b = 32'd3; op_tag = 4'd1; step();
      op_a = 32'd8; op_b = 32'd8; op_tag = 4'd2; step();
      op_a = 32'd5; op_b = 32'd0; op_tag = 4'd3; step();
      op_val = 1'b0;
      cyc = 3; k = 0; prev = 0;
      while (k < 3 && cyc < 300) begin
         if (res_val) begin
            check($sformatf("tput%0d data", k), res_data, exp3[k].data);
            check($sformatf("tput%0d tag", k), res_tag, exp3[k].tag);
            check($sformatf("tput%0d steps", k), res_steps, exp3[k].steps);
            if (k == 0) check("tput0 latency", cyc, 3 + exp3[0].steps);
            else        check($sformatf("tput%0d gap", k), cyc - prev, 2 + exp3[k].steps);
            prev = cyc;
            k++;
         end
         step();
         cyc++;
      end
      check("tput count", k, 3);
      step();

      // Backpressure: six offers, five accepted, then a stable held result.
      res_rdy = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         op_a = 32'd12 * (i + 2); op_b = 32'd18 + i; op_tag = 4'(i); op_val = 1'b1;
         if (i < 5) expb[i] = model(op_a, op_b, op_tag);
         acc += int'(op_rdy);
         step();
      end
      op_val = 1'b0;
      check("full accepted", acc, 5);
      check("full operands_rdy", op_rdy, 0);
      check("full queue_count", q_count, 4);
      cyc = 0;
      while (!res_val && cyc < 500) begin step(); cyc++; end
      check("full first val", res_val, 1);
      snap = {res_data, res_tag, res_steps};
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!res_val || {res_data, res_tag, res_steps} != snap) stable = 1'b0;
      end
      check("full hold stable", stable, 1);
      res_rdy = 1'b1;
      k = 0; cyc = 0;
      while (k < 5 && cyc < 2000) begin
         if (res_val) begin
            check($sformatf("full%0d data", k), res_data, expb[k].data);
            check($sformatf("full%0d tag", k), res_tag, expb[k].tag);
            check($sformatf("full%0d steps", k), res_steps, expb[k].steps);
            k++;
         end
         step();
         cyc++;
      end
      check("full result count", k, 5);
      step();
      check("full drained count", q_count, 0);

      // Randomized traffic with random backpressure against the model.
      held = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         op_val  = (c < 2500) && ($urandom_range(0, 3) != 0);
         op_a    = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 255));
         op_b    = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 255));
         op_tag  = 4'($urandom_range(0, 15));
         res_rdy = (c >= 2500) || ($urandom_range(0, 2) != 0);
         if (op_val && op_rdy) expq.push_back(model(op_a, op_b, op_tag));
         if (held) begin
            check("rand hold val", res_val, 1);
            check("rand hold fields", {res_data, res_tag, res_steps}, snap);
         end
         if (res_val && res_rdy) begin
            if (expq.size() == 0) check("rand spurious result", 1, 0);
            else begin
               e = expq.pop_front();
               check("rand data", res_data, e.data);
               check("rand tag", res_tag, e.tag);
               check("rand steps", res_steps, e.steps);
            end
         end
         held = res_val && !res_rdy;
         snap = {res_data, res_tag, res_steps};
         step();
      end
      op_val = 1'b0;
      check("rand drained", expq.size(), 0);

      // Reset mid-computation discards in-flight and queued work.
      res_rdy = 1'b1;
      op_val = 1'b1;
      op_a = 32'd100000; op_b = 32'd1; op_tag = 4'd1; step();
      op_a = 32'd20;     op_b = 32'd8; op_tag = 4'd2; step();
      op_a = 32'd7;      op_b = 32'd7; op_tag = 4'd3; step();
      op_val = 1'b0;
      for (int i = 3; i < 50; i++) step();
      check("pre-reset queue_count", q_count, 2);
      reset = 1'b1;
      #1;
      check("async rst val", res_val, 0);
      check("async rst data", res_data, 0);
      check("async rst steps", res_steps, 0);
      check("async rst queue_count", q_count, 0);
      check("async rst operands_rdy", op_rdy, 1);
      step();
      reset = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (res_val || q_count != 0) saw = 1'b1;
      end
      check("no stale result", saw, 0);
      e = model(32'd6, 32'd4, 4'd9);
      op_a = 32'd6; op_b = 32'd4; op_tag = 4'd9; op_val = 1'b1;
      step();
      op_val = 1'b0;
      cyc = 1;
      while (!res_val && cyc < 200) begin step(); cyc++; end
      check("post-reset latency", cyc, 3 + e.steps);
      check("post-reset data", res_data, e.data);
      check("post-reset tag", res_tag, e.tag);
      check("post-reset steps", res_steps, e.steps);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
